// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, addresses the instruction ROM and
// fills the IF/ID pipeline register, with stall/flush/redirect and a sticky fetch fault.
module fetch_stage #(
  parameter int unsigned                ADDRESS_WIDTH = 32,
  parameter int unsigned                DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = 32'h0000_0000,
  parameter int unsigned                IMEM_BYTES    = 4096
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall_i,
  input  logic                     flush_i,
  input  logic [1:0]               pc_src_i,
  input  logic [ADDRESS_WIDTH-1:0] branch_target_i,
  input  logic [ADDRESS_WIDTH-1:0] jalr_target_i,
  output logic [ADDRESS_WIDTH-1:0] imem_addr_o,
  input  logic [DATA_WIDTH-1:0]    imem_instr_i,
  output logic [DATA_WIDTH-1:0]    id_instr_o,
  output logic [ADDRESS_WIDTH-1:0] id_pc_o,
  output logic [ADDRESS_WIDTH-1:0] id_pc_plus4_o,
  output logic                     id_valid_o,
  output logic                     fault_o,
  output logic [ADDRESS_WIDTH-1:0] fault_addr_o
);

  typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;
  typedef enum logic [1:0] {IFID_HOLD, IFID_BUBBLE, IFID_LOAD} ifid_sel_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]    instr;
    logic [ADDRESS_WIDTH-1:0] pc;
    logic [ADDRESS_WIDTH-1:0] pc_plus4;
    logic                     valid;
  } ifid_t;

  // Bubble is addi x0,x0,0 so decode sees a harmless NOP.
  localparam ifid_t BUBBLE = '{
    instr:    DATA_WIDTH'(32'h0000_0013),
    pc:       '0,
    pc_plus4: '0,
    valid:    1'b0
  };

  localparam logic [ADDRESS_WIDTH-1:0] PC_MAX = ADDRESS_WIDTH'(IMEM_BYTES - 4);

  state_t                   state, state_next;
  ifid_sel_t                ifid_sel;
  ifid_t                    ifid;
  logic [ADDRESS_WIDTH-1:0] pc, pc_plus4, next_pc;
  logic                     pc_advance, next_pc_bad, pc_we, fault_set;
  logic                     fault;
  logic [ADDRESS_WIDTH-1:0] fault_addr;

  assign pc_plus4 = pc + ADDRESS_WIDTH'(4);

  // NOTE: every always_comb output gets a default first, otherwise a path
  // that skips the assignment infers a latch.
  always_comb begin
    next_pc = pc_plus4;
    case (pc_src_i)
      2'b01:   next_pc = branch_target_i;
      2'b10:   next_pc = jalr_target_i & ~ADDRESS_WIDTH'(1);
      default: next_pc = pc_plus4;
    endcase
  end

  // Flush overrides stall; the fault check only matters when the PC would move.
  assign pc_advance  = (state == RUN) && (!stall_i || flush_i);
  assign next_pc_bad = (next_pc[1:0] != 2'b00) || (next_pc > PC_MAX);

  // NOTE: async active-low reset sits in the sensitivity list, and sequential
  // state uses non-blocking assignments so all registers sample the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      BOOT:    state_next = RUN;
      RUN:     if (pc_advance && next_pc_bad) state_next = FAULT;
      FAULT:   state_next = FAULT;
      default: state_next = BOOT;
    endcase
  end

  always_comb begin
    pc_we     = 1'b0;
    fault_set = 1'b0;
    ifid_sel  = IFID_BUBBLE;
    if (state == RUN) begin
      if (!pc_advance) begin
        ifid_sel = IFID_HOLD;
      end else if (next_pc_bad) begin
        fault_set = 1'b1;
      end else begin
        pc_we    = 1'b1;
        ifid_sel = flush_i ? IFID_BUBBLE : IFID_LOAD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     pc <= RESET_PC;
    else if (pc_we) pc <= next_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid <= BUBBLE;
    end else begin
      case (ifid_sel)
        IFID_LOAD:   ifid <= '{instr: imem_instr_i, pc: pc, pc_plus4: pc_plus4, valid: 1'b1};
        IFID_BUBBLE: ifid <= BUBBLE;
        default:     ifid <= ifid;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault      <= 1'b0;
      fault_addr <= '0;
    end else if (fault_set) begin
      fault      <= 1'b1;
      fault_addr <= next_pc;
    end
  end

  assign imem_addr_o   = pc;
  assign id_instr_o    = ifid.instr;
  assign id_pc_o       = ifid.pc;
  assign id_pc_plus4_o = ifid.pc_plus4;
  assign id_valid_o    = ifid.valid;
  assign fault_o       = fault;
  assign fault_addr_o  = fault_addr;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: boot, sequential fetch, branch, stall, JALR,
// misaligned and out-of-range faults, and asynchronous reset.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i, flush_i;
  logic [1:0]  pc_src_i;
  logic [31:0] branch_target_i, jalr_target_i;
  logic [31:0] imem_addr_o, imem_instr_i;
  logic [31:0] id_instr_o, id_pc_o, id_pc_plus4_o, fault_addr_o;
  logic        id_valid_o, fault_o;

  int checks = 0;
  int errors = 0;

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_i        (stall_i),
    .flush_i        (flush_i),
    .pc_src_i       (pc_src_i),
    .branch_target_i(branch_target_i),
    .jalr_target_i  (jalr_target_i),
    .imem_addr_o    (imem_addr_o),
    .imem_instr_i   (imem_instr_i),
    .id_instr_o     (id_instr_o),
    .id_pc_o        (id_pc_o),
    .id_pc_plus4_o  (id_pc_plus4_o),
    .id_valid_o     (id_valid_o),
    .fault_o        (fault_o),
    .fault_addr_o   (fault_addr_o)
  );

  always #5 clk = ~clk;

  // ROM model: the byte at address i holds i[7:0], little-endian words.
  always_comb begin
    imem_instr_i = {imem_addr_o[7:0] + 8'd3, imem_addr_o[7:0] + 8'd2,
                    imem_addr_o[7:0] + 8'd1, imem_addr_o[7:0]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall_i = 1'b0;
    flush_i = 1'b0;
    pc_src_i = 2'b00;
    branch_target_i = 32'h0;
    jalr_target_i = 32'h0;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    check("rst imem_addr", imem_addr_o, 32'h0);
    check("rst id_valid", {31'b0, id_valid_o}, 32'h0);
    check("rst id_instr", id_instr_o, 32'h0000_0013);
    check("rst fault", {31'b0, fault_o}, 32'h0);
    check("rst fault_addr", fault_addr_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b1;
    #2;
    reset_pulse();

    // Boot and sequential fetch
    step();
    check("boot id_valid", {31'b0, id_valid_o}, 32'h0);
    check("boot imem_addr", imem_addr_o, 32'h0);
    step();
    check("seq0 id_valid", {31'b0, id_valid_o}, 32'h1);
    check("seq0 id_pc", id_pc_o, 32'h0);
    check("seq0 id_instr", id_instr_o, 32'h0302_0100);
    check("seq0 id_pc_plus4", id_pc_plus4_o, 32'h4);
    pc_src_i = 2'b11;  // behaves as PC+4
    branch_target_i = 32'h0000_0080;
    step();
    check("seq1 id_pc", id_pc_o, 32'h4);
    check("seq1 id_instr", id_instr_o, 32'h0706_0504);
    step();
    check("seq2 id_pc", id_pc_o, 32'h8);
    check("seq2 imem_addr", imem_addr_o, 32'hC);
    idle_inputs();
    step();
    check("seq3 imem_addr", imem_addr_o, 32'h10);

    // Branch with flush at PC=0x10
    pc_src_i = 2'b01;
    branch_target_i = 32'h40;
    flush_i = 1'b1;
    step();
    check("br imem_addr", imem_addr_o, 32'h40);
    check("br id_valid", {31'b0, id_valid_o}, 32'h0);
    idle_inputs();
    step();
    check("br id_pc", id_pc_o, 32'h40);
    check("br id_pc_plus4", id_pc_plus4_o, 32'h44);
    check("br id_instr", id_instr_o, 32'h4342_4140);

    // Mid-run asynchronous reset, then stall at PC=0x8
    reset_pulse();
    step();
    step();
    step();
    check("pre-stall imem_addr", imem_addr_o, 32'h8);
    stall_i = 1'b1;
    pc_src_i = 2'b01;  // ignored while stalled
    branch_target_i = 32'h100;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall imem_addr", imem_addr_o, 32'h8);
      check("stall id_pc", id_pc_o, 32'h4);
      check("stall id_valid", {31'b0, id_valid_o}, 32'h1);
    end
    idle_inputs();
    step();
    check("resume id_pc", id_pc_o, 32'h8);
    step();
    check("resume2 id_pc", id_pc_o, 32'hC);
    check("resume2 imem_addr", imem_addr_o, 32'h10);

    // Stall+flush with JALR: bit 0 cleared, bubble, no fault
    stall_i = 1'b1;
    flush_i = 1'b1;
    pc_src_i = 2'b10;
    jalr_target_i = 32'h25;
    step();
    check("jalr imem_addr", imem_addr_o, 32'h24);
    check("jalr id_valid", {31'b0, id_valid_o}, 32'h0);
    check("jalr fault", {31'b0, fault_o}, 32'h0);

    // Misaligned JALR target -> fault
    idle_inputs();
    pc_src_i = 2'b10;
    jalr_target_i = 32'h26;
    step();
    check("mis fault", {31'b0, fault_o}, 32'h1);
    check("mis fault_addr", fault_addr_o, 32'h26);
    check("mis imem_addr", imem_addr_o, 32'h24);
    check("mis id_valid", {31'b0, id_valid_o}, 32'h0);
    idle_inputs();
    pc_src_i = 2'b01;
    branch_target_i = 32'h40;
    flush_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("fault held", {31'b0, fault_o}, 32'h1);
      check("fault addr held", fault_addr_o, 32'h26);
      check("fault pc frozen", imem_addr_o, 32'h24);
      check("fault id_valid", {31'b0, id_valid_o}, 32'h0);
    end
    idle_inputs();

    // Run off the end of the ROM
    reset_pulse();
    step();
    step();
    pc_src_i = 2'b01;
    branch_target_i = 32'hFF8;
    step();
    check("end imem_addr", imem_addr_o, 32'hFF8);
    idle_inputs();
    step();
    check("last imem_addr", imem_addr_o, 32'hFFC);
    check("last fault", {31'b0, fault_o}, 32'h0);
    check("last id_pc", id_pc_o, 32'hFF8);
    step();
    check("oor fault", {31'b0, fault_o}, 32'h1);
    check("oor fault_addr", fault_addr_o, 32'h1000);
    check("oor imem_addr", imem_addr_o, 32'hFFC);
    check("oor id_valid", {31'b0, id_valid_o}, 32'h0);
    reset_pulse();
    step();
    step();
    check("post-fault id_pc", id_pc_o, 32'h0);
    check("post-fault id_valid", {31'b0, id_valid_o}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the RV32I core: owns the program counter, drives the byte address into the instruction ROM, and captures the returned 32-bit little-endian word into the IF/ID pipeline register for decode. It selects the next PC from sequential, branch and JALR sources, honours stall/flush from hazard control, and halts fetch on a misaligned or out-of-range PC.

## Interface
- ADDRESS_WIDTH, 32, PC/address width
- DATA_WIDTH, 32, instruction width
- RESET_PC, 32'h0000_0000, PC loaded on reset
- IMEM_BYTES, 4096, instruction ROM size in bytes; legal PC range 0 .. IMEM_BYTES-4
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- stall_i  input  1  hold PC and IF/ID register
- flush_i  input  1  load bubble into IF/ID
- pc_src_i  input  2  next-PC select: 00 PC+4, 01 branch, 10 JALR, 11 treated as 00
- branch_target_i  input  ADDRESS_WIDTH  branch/JAL target
- jalr_target_i  input  ADDRESS_WIDTH  JALR target (bit 0 cleared internally)
- imem_addr_o  output  ADDRESS_WIDTH  byte address to instruction ROM (= PC)
- imem_instr_i  input  DATA_WIDTH  word returned combinationally by ROM
- id_instr_o  output  DATA_WIDTH  IF/ID instruction
- id_pc_o  output  ADDRESS_WIDTH  IF/ID PC
- id_pc_plus4_o  output  ADDRESS_WIDTH  IF/ID PC+4
- id_valid_o  output  1  IF/ID holds a real instruction
- fault_o  output  1  fetch fault, sticky until reset
- fault_addr_o  output  ADDRESS_WIDTH  offending next-PC value

## Operation
- States: BOOT, RUN, FAULT. Reset -> BOOT.
- BOOT: one cycle; PC holds RESET_PC, IF/ID loads bubble; -> RUN.
- RUN, per edge, priority order:
  - next_pc = PC+4 / branch_target_i / {jalr_target_i[31:1],1'b0} per pc_src_i.
  - stall_i=1, flush_i=0: PC and IF/ID hold; pc_src_i ignored.
  - Fault check on next_pc when PC would update: next_pc[1:0]!=0 or next_pc > IMEM_BYTES-4 -> FAULT, PC holds, fault_addr_o=next_pc, IF/ID loads bubble.
  - flush_i=1 (regardless of stall_i): PC <= next_pc (subject to fault check), IF/ID loads bubble.
  - Otherwise: PC <= next_pc; IF/ID <= {imem_instr_i, PC, PC+4, valid=1}.
- FAULT: PC frozen, IF/ID bubble, all inputs ignored; exit only via reset.
- Bubble: id_instr_o=32'h0000_0013 (addi x0,x0,0), id_pc_o=0, id_pc_plus4_o=0, id_valid_o=0.
- PC+4 is modulo 2^ADDRESS_WIDTH; wrap never reaches ROM because range check faults first.

## Timing
- Reset (async, immediate): PC=RESET_PC, state BOOT, IF/ID=bubble, fault_o=0, fault_addr_o=0. imem_addr_o=RESET_PC.
- imem_addr_o is combinational from PC register; no registered ROM output assumed.
- First valid decode: id_valid_o=1 with id_pc_o=RESET_PC after 2nd rising edge following rst_n release.
- Redirect latency: target on imem_addr_o 1 cycle after pc_src_i selects it; in IF/ID after 2nd edge.
- Stall of N cycles holds all outputs N cycles; resumption continues from held PC with no lost/duplicated instruction.
- fault_o rises on the edge that would have committed the bad PC; never deasserts until rst_n low.
- rst_n asserted mid-stall, mid-redirect or in FAULT: all state returns to reset values immediately.

## Test plan
- Reset/sequential: ROM word at byte i = i; release rst_n -> edge 2: id_pc_o=0, id_instr_o=0x03020100, id_valid_o=1; edges 3,4: id_pc_o=4,8.
- Branch: at PC=0x10 drive pc_src_i=01, branch_target_i=0x40, flush_i=1 -> imem_addr_o=0x40 next cycle, id_valid_o=0, then id_pc_o=0x40, id_pc_plus4_o=0x44.
- Stall: stall_i=1 for 3 cycles at PC=0x8 -> imem_addr_o=0x8 and id_pc_o=0x4 held 3 cycles; release -> id_pc_o=0x8, then 0xC.
- Stall+flush with pc_src_i=10, jalr_target_i=0x25 -> PC=0x24, IF/ID bubble, no fault.
- Misaligned: jalr_target_i=0x26 -> fault_o=1, fault_addr_o=0x26, PC held, id_valid_o=0 permanently until reset.
- Run off end: sequential fetch to PC=0xFFC -> next edge fault_o=1, fault_addr_o=0x1000; pull rst_n low -> fault_o=0, imem_addr_o=0 immediately.
